// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared cathode bus, NUM_DIGITS
// common-anode digits, blanking between slots and frame-aligned data update.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [2:0]              cur_digit,
  output logic                    frame_done
);
  localparam int MAXC = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    LAST_DIG   = 3'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [2:0]                   cur_q, cur_d;
  logic                         en_q, en_d;
  logic                         pending_q, pending_d;
  logic [NUM_DIGITS-1:0][3:0]   pend_q, pend_d;
  logic [NUM_DIGITS-1:0][3:0]   shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]        an_q, an_d;
  logic [6:0]                   seg_q, seg_d;
  logic                         fd_q, fd_d;
  logic [IW-1:0]                idx_q, idx_d;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'b0000001;  4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;  4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;  4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;  4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;  4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;  4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;  4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;  default: decode = 7'b0111000;
    endcase
  endfunction

  assign idx_q = cur_q[IW-1:0];
  assign idx_d = cur_d[IW-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    cur_d     = cur_q;
    en_d      = en_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    shadow_d  = shadow_q;
    fd_d      = 1'b0;
    if (load) begin
      pend_d    = digit_data;
      pending_d = 1'b1;
    end
    case (state_q)
      BLANK: if (cnt_q == BLANK_LAST) begin
        state_d = SHOW;
        cnt_d   = '0;
        en_d    = digit_en[idx_q];
        // Frame boundary: the whole pending word moves at once, so a frame never mixes loads.
        if (cur_q == 3'd0 && pending_q) begin
          shadow_d = pend_q;
          if (!load) pending_d = 1'b0;
        end
      end
      default: if (cnt_q == SHOW_LAST) begin
        state_d = BLANK;
        cnt_d   = '0;
        cur_d   = (cur_q == LAST_DIG) ? 3'd0 : cur_q + 3'd1;
        fd_d    = (cur_q == LAST_DIG);
      end
    endcase
    // Outputs are registered from next-state values so they change with the state.
    an_d  = '1;
    seg_d = 7'h7F;
    if (state_d == SHOW && en_d) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = decode(shadow_d[idx_d]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      cur_q     <= '0;
      en_q      <= 1'b0;
      pending_q <= 1'b0;
      pend_q    <= '0;
      shadow_q  <= '0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      en_q      <= en_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      shadow_q  <= shadow_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      fd_q      <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign an         = an_q;
  assign cur_digit  = cur_q;
  assign frame_done = fd_q;
endmodule
